// File: rtl/fetch_unit_if.sv
// fetch_unit_if: redirect, instruction-memory and buffer-push signals of the fetch unit
interface fetch_unit_if #(
    parameter int PUSH_W = 2,
    parameter int IB_IDX_BITS = 4
);
    logic redirect_valid;
    logic [31:0] redirect_pc;
    logic [IB_IDX_BITS:0] ib_available_slots;
    logic imem_req_valid;
    logic [31:0] imem_req_addr;
    logic imem_req_ready;
    logic imem_resp_valid;
    logic [32*PUSH_W-1:0] imem_resp_data;
    logic [$clog2(PUSH_W+1)-1:0] ib_num_pushes;
    logic [32*PUSH_W-1:0] ib_inst;
    logic [32*PUSH_W-1:0] ib_pc;
    logic [32*PUSH_W-1:0] ib_npc;
    modport master (
        input redirect_valid, redirect_pc, ib_available_slots, imem_req_ready, imem_resp_valid, imem_resp_data,
        output imem_req_valid, imem_req_addr, ib_num_pushes, ib_inst, ib_pc, ib_npc
    );
    modport slave (
        output redirect_valid, redirect_pc, ib_available_slots, imem_req_ready, imem_resp_valid, imem_resp_data,
        input imem_req_valid, imem_req_addr, ib_num_pushes, ib_inst, ib_pc, ib_npc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC walker issuing block requests and pushing returned words into the instruction buffer
module fetch_unit #(
    parameter int PUSH_W = 2,
    parameter int IB_IDX_BITS = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic clock,
    input logic reset,
    fetch_unit_if.master fu
);
    localparam int NW = $clog2(PUSH_W + 1);
    localparam logic [31:0] BLK = 32'(4 * PUSH_W);
    typedef enum logic [1:0] {FETCH, WAIT, PUSH, DRAIN} state_t;
    state_t state;
    logic [31:0] pc, base, off, need, off_q, k;
    logic [NW-1:0] need_q;
    logic [32*PUSH_W-1:0] inst_n, pc_n, npc_n;
    logic accept;
    always_comb begin
        base = pc & ~(BLK - 32'd1);
        off = (pc >> 2) & 32'(PUSH_W - 1);
        need = 32'(PUSH_W) - off;
        fu.imem_req_valid = !reset && state == FETCH && !fu.redirect_valid &&
                            {{(31-IB_IDX_BITS){1'b0}}, fu.ib_available_slots} >= need;
        fu.imem_req_addr = base;
        fu.ib_num_pushes = (!reset && state == PUSH && !fu.redirect_valid) ? need_q : '0;
        accept = fu.imem_req_valid && fu.imem_req_ready;
    end
    // word off+i of the block lands in entry i; entries past the block end stay zero
    always_comb begin
        inst_n = '0;
        pc_n = '0;
        npc_n = '0;
        k = '0;
        for (int i = 0; i < PUSH_W; i++) begin
            k = off_q + 32'(i);
            inst_n[32*i +: 32] = (32'(i) < 32'(need_q)) ? 32'(fu.imem_resp_data >> (32 * k)) : '0;
            pc_n[32*i +: 32] = (32'(i) < 32'(need_q)) ? base + (k << 2) : '0;
            npc_n[32*i +: 32] = (32'(i) < 32'(need_q)) ? base + (k << 2) + 32'd4 : '0;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
            pc <= RESET_PC;
            off_q <= '0;
            need_q <= '0;
            fu.ib_inst <= '0;
            fu.ib_pc <= '0;
            fu.ib_npc <= '0;
        end else if (fu.redirect_valid) begin
            pc <= fu.redirect_pc;
            state <= ((state == WAIT || state == DRAIN) && !fu.imem_resp_valid) ? DRAIN : FETCH;
        end else begin
            case (state)
                FETCH: if (accept) begin
                    state <= WAIT;
                    off_q <= off;
                    need_q <= NW'(need);
                end
                WAIT: if (fu.imem_resp_valid) begin
                    state <= PUSH;
                    fu.ib_inst <= inst_n;
                    fu.ib_pc <= pc_n;
                    fu.ib_npc <= npc_n;
                end
                PUSH: begin
                    pc <= base + BLK;
                    state <= FETCH;
                end
                DRAIN: if (fu.imem_resp_valid) state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random redirects/slots/latency against a program-order fetch model with request and push scoreboards
module tb_fetch_unit;
    localparam int PW = 2;
    localparam int IBB = 4;
    localparam int W = 32 * PW;
    localparam logic [31:0] RPC = 32'h0;
    localparam logic [31:0] BLK = 32'(4 * PW);

    typedef struct {
        int cyc;
        bit v;
        logic [31:0] addr;
    } req_t;
    typedef struct {
        int cyc;
        int num;
        logic [W-1:0] inst;
        logic [W-1:0] pc;
        logic [W-1:0] npc;
    } push_t;

    logic clock = 0;
    logic reset;
    fetch_unit_if #(.PUSH_W(PW), .IB_IDX_BITS(IBB)) bus();
    fetch_unit #(.PUSH_W(PW), .IB_IDX_BITS(IBB), .RESET_PC(RPC)) dut (
        .clock(clock),
        .reset(reset),
        .fu(bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    req_t req_q[$];
    push_t push_q[$];

    logic [31:0] exp_pc = RPC;
    logic [31:0] req_pc, pend_next, mem_addr;
    bit outstanding = 0, squashed = 0, pp = 0, mem_busy = 0;
    int mem_cnt = 0;
    push_t pend;

    function automatic logic [31:0] f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // instructions from p up to the end of its block, in program order
    function automatic push_t build(input logic [31:0] p);
        push_t t;
        logic [31:0] q;
        t.cyc = 0;
        t.num = PW - int'((p >> 2) % PW);
        t.inst = '0;
        t.pc = '0;
        t.npc = '0;
        for (int i = 0; i < PW; i++) begin
            q = p + 32'(4 * i);
            if (i < t.num) begin
                t.pc[32*i +: 32] = q;
                t.inst[32*i +: 32] = f(q);
                t.npc[32*i +: 32] = q + 32'd4;
            end
        end
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    endtask

    task automatic step(input bit rs, input bit rv, input logic [31:0] rpc, input int sl, input bit rdy, input int lat);
        bit resp, old_pp, ve;
        logic [31:0] blk;
        int need;
        @(negedge clock);
        cyc++;
        resp = mem_busy && mem_cnt == 0;
        reset = rs;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        bus.ib_available_slots = sl[IBB:0];
        bus.imem_req_ready = rdy;
        bus.imem_resp_valid = resp;
        for (int i = 0; i < PW; i++)
            bus.imem_resp_data[32*i +: 32] = resp ? f(mem_addr + 32'(4 * i)) : $urandom;
        if (mem_busy) begin
            if (resp) mem_busy = 0;
            else mem_cnt--;
        end
        old_pp = pp;
        pp = 0;
        blk = exp_pc & ~(BLK - 32'd1);
        need = PW - int'((exp_pc >> 2) % PW);
        ve = !rs && !outstanding && !old_pp && !rv && sl >= need;
        req_q.push_back('{cyc, ve, blk});
        if (rs) begin
            outstanding = 0;
            squashed = 0;
            exp_pc = RPC;
        end else begin
            if (old_pp && !rv) begin
                pend.cyc = cyc;
                push_q.push_back(pend);
                exp_pc = pend_next;
            end
            if (ve && rdy) begin
                outstanding = 1;
                squashed = 0;
                req_pc = exp_pc;
                mem_busy = 1;
                mem_cnt = lat;
                mem_addr = blk;
            end
            if (resp && outstanding) begin
                outstanding = 0;
                if (!squashed && !rv) begin
                    pp = 1;
                    pend = build(req_pc);
                    pend_next = (req_pc & ~(BLK - 32'd1)) + BLK;
                end
            end
            if (rv) begin
                exp_pc = rpc;
                if (outstanding) squashed = 1;
            end
        end
    endtask

    task automatic check_regs_zero(input string tag);
        #1;
        chk({tag, "_inst"}, bus.ib_inst, '0);
        chk({tag, "_pc"}, bus.ib_pc, '0);
        chk({tag, "_npc"}, bus.ib_npc, '0);
    endtask

    initial begin
        req_t r;
        push_t p;
        forever begin
            @(negedge clock);
            #2;
            if (req_q.size() != 0) begin
                r = req_q.pop_front();
                chk("req_valid", bus.imem_req_valid, r.v);
                if (r.v) chk("req_addr", bus.imem_req_addr, r.addr);
            end
            if (bus.ib_num_pushes != 0) begin
                if (push_q.size() == 0) chk("unexpected_push", bus.ib_num_pushes, 0);
                else begin
                    p = push_q.pop_front();
                    chk("push_cycle", cyc, p.cyc);
                    chk("num_pushes", bus.ib_num_pushes, p.num);
                    chk("ib_inst", bus.ib_inst, p.inst);
                    chk("ib_pc", bus.ib_pc, p.pc);
                    chk("ib_npc", bus.ib_npc, p.npc);
                end
            end else if (push_q.size() != 0 && push_q[0].cyc <= cyc) begin
                p = push_q.pop_front();
                chk("missed_push", 0, p.num);
            end
        end
    end

    initial begin
        reset = 1;
        bus.redirect_valid = 0;
        bus.redirect_pc = '0;
        bus.ib_available_slots = '0;
        bus.imem_req_ready = 0;
        bus.imem_resp_valid = 0;
        bus.imem_resp_data = '0;
        repeat (2) step(1, 0, 0, 16, 1, 0);
        check_regs_zero("reset");
        repeat (3) step(0, 0, 0, 1, 1, 0);
        repeat (12) step(0, 0, 0, 16, 1, 0);
        step(0, 1, 32'h104, 16, 1, 0);
        repeat (8) step(0, 0, 0, 16, 1, 0);
        step(0, 1, 32'h4, 1, 1, 0);
        repeat (5) step(0, 0, 0, 1, 1, 0);
        repeat (5) step(0, 0, 0, 16, 0, 0);
        repeat (6) step(0, 0, 0, 16, 1, 2);
        repeat (6) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 16, 1, 3);
        step(0, 1, 32'h40, 16, 1, 0);
        repeat (10) step(0, 0, 0, 16, 1, 0);
        step(0, 1, 32'hFFFF_FFF8, 16, 1, 0);
        repeat (8) step(0, 0, 0, 16, 1, 0);
        repeat (3000) begin
            logic [31:0] rp;
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
            step(0, $urandom_range(0, 11) == 0, rp, $urandom_range(0, 16), $urandom_range(0, 3) != 0, $urandom_range(0, 3));
        end
        repeat (8) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 16, 1, 3);
        step(1, 0, 0, 16, 0, 0);
        step(0, 0, 0, 16, 0, 0);
        check_regs_zero("reset_mid_wait");
        repeat (5) step(0, 0, 0, 16, 0, 0);
        repeat (10) step(0, 0, 0, 16, 1, 0);
        @(negedge clock);
        #3;
        chk("push_queue_drained", push_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
